// File: rtl/certificate_sender_pkg.sv
// Shared constants for the certificate sender/compare pair: payload width,
// per-slot chunk counts and data, slot and FSM state encodings.
package certificate_sender_pkg;

  localparam int MSG_LEN                 = 64;
  localparam int SIZE_OF_HEADER_VARS     = 4;
  localparam int SIZE_OF_HEADER_IN_BYTES = 8;
  localparam int PAYLOAD_W = MSG_LEN - (SIZE_OF_HEADER_VARS * SIZE_OF_HEADER_IN_BYTES);

  localparam int SLOT0_NUM_CERTS = 6;
  localparam int SLOT1_NUM_CERTS = 4;
  localparam int SLOT2_NUM_CERTS = 5;

  typedef enum logic [1:0] {
    SLOT_0       = 2'd0,
    SLOT_1       = 2'd1,
    SLOT_2       = 2'd2,
    SLOT_INVALID = 2'd3
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  localparam logic [PAYLOAD_W-1:0] SLOT0_CERT1 = 32'h3082_0101;
  localparam logic [PAYLOAD_W-1:0] SLOT0_CERT2 = 32'h5A17_C302;
  localparam logic [PAYLOAD_W-1:0] SLOT0_CERT3 = 32'h9E44_0B13;
  localparam logic [PAYLOAD_W-1:0] SLOT0_CERT4 = 32'h1D6F_A024;
  localparam logic [PAYLOAD_W-1:0] SLOT0_CERT5 = 32'hC3B2_7E35;
  localparam logic [PAYLOAD_W-1:0] SLOT0_CERT6 = 32'h0F0F_F0F6;
  localparam logic [PAYLOAD_W-1:0] SLOT1_CERT1 = 32'h7711_2201;
  localparam logic [PAYLOAD_W-1:0] SLOT1_CERT2 = 32'hB00C_5A12;
  localparam logic [PAYLOAD_W-1:0] SLOT1_CERT3 = 32'h4E4F_C0F3;
  localparam logic [PAYLOAD_W-1:0] SLOT1_CERT4 = 32'hDEAD_BEE4;
  localparam logic [PAYLOAD_W-1:0] SLOT2_CERT1 = 32'h1234_5671;
  localparam logic [PAYLOAD_W-1:0] SLOT2_CERT2 = 32'hFACE_0B02;
  localparam logic [PAYLOAD_W-1:0] SLOT2_CERT3 = 32'h8888_1113;
  localparam logic [PAYLOAD_W-1:0] SLOT2_CERT4 = 32'h600D_F00D;
  localparam logic [PAYLOAD_W-1:0] SLOT2_CERT5 = 32'hCAFE_D00D;

  function automatic logic [7:0] num_certs(input logic [1:0] slot);
    case (slot)
      SLOT_0:  return 8'(SLOT0_NUM_CERTS);
      SLOT_1:  return 8'(SLOT1_NUM_CERTS);
      SLOT_2:  return 8'(SLOT2_NUM_CERTS);
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/certificate_sender_if.sv
// Request/payload/ack bundle between responder FSM, framer and certificate sender.
// Payload handshake: a chunk transfers on a cycle where Payload_valid && Payload_ready;
// Payload_out is held stable while Payload_valid && !Payload_ready.
interface certificate_sender_if;
  import certificate_sender_pkg::*;

  logic                 Enable;
  logic                 Request;
  logic [1:0]           slot;
  logic                 Payload_ready;
  logic                 Ack;
  logic                 Nack;
  logic                 Payload_valid;
  logic [PAYLOAD_W-1:0] Payload_out;
  logic [7:0]           counter;
  logic                 Busy;
  logic                 Done;
  logic                 Error_Invalid_Slot;
  logic                 Error_Abort;

  modport master (
    output Enable, Request, slot, Payload_ready, Ack, Nack,
    input  Payload_valid, Payload_out, counter, Busy, Done, Error_Invalid_Slot, Error_Abort
  );

  modport slave (
    input  Enable, Request, slot, Payload_ready, Ack, Nack,
    output Payload_valid, Payload_out, counter, Busy, Done, Error_Invalid_Slot, Error_Abort
  );

endinterface

// File: rtl/certificate_rom.sv
// Combinational certificate store: (slot, 1-based index) -> chunk data, plus the
// chunk count of the slot. Out-of-range index or invalid slot returns 0.
module certificate_rom
  import certificate_sender_pkg::*;
(
  input  logic [1:0]           slot,
  input  logic [7:0]           index,
  output logic [PAYLOAD_W-1:0] data,
  output logic [7:0]           count
);

  always_comb begin
    data  = '0;
    count = num_certs(slot);
    case (slot)
      SLOT_0: begin
        case (index)
          8'd1:    data = SLOT0_CERT1;
          8'd2:    data = SLOT0_CERT2;
          8'd3:    data = SLOT0_CERT3;
          8'd4:    data = SLOT0_CERT4;
          8'd5:    data = SLOT0_CERT5;
          8'd6:    data = SLOT0_CERT6;
          default: data = '0;
        endcase
      end
      SLOT_1: begin
        case (index)
          8'd1:    data = SLOT1_CERT1;
          8'd2:    data = SLOT1_CERT2;
          8'd3:    data = SLOT1_CERT3;
          8'd4:    data = SLOT1_CERT4;
          default: data = '0;
        endcase
      end
      SLOT_2: begin
        case (index)
          8'd1:    data = SLOT2_CERT1;
          8'd2:    data = SLOT2_CERT2;
          8'd3:    data = SLOT2_CERT3;
          8'd4:    data = SLOT2_CERT4;
          8'd5:    data = SLOT2_CERT5;
          default: data = '0;
        endcase
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/certificate_sender.sv
// Streams the certificate chunks of one slot to the framer, waiting for a peer
// Ack per chunk and retransmitting on Nack/timeout up to MAX_RETRY times.
module certificate_sender
  import certificate_sender_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 2
) (
  input  logic                 clk,
  input  logic                 Reset,
  certificate_sender_if.slave  bus,
  output state_e               dbg_state
);

  localparam int              RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]   RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [15:0]     TIMER_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_e               state, state_nx;
  logic [1:0]           slot_q, slot_nx;
  logic [7:0]           counter_q, counter_nx;
  logic [RW-1:0]        retry_q, retry_nx;
  logic [15:0]          timer_q, timer_nx;
  logic                 done_q, done_nx;
  logic                 inv_q, inv_nx;
  logic                 abort_q, abort_nx;
  logic [PAYLOAD_W-1:0] payload_q, payload_nx;
  logic [PAYLOAD_W-1:0] rom_data;
  logic [7:0]           rom_count;

  // Looked up with next-cycle slot/index so Payload_out is a plain register.
  certificate_rom u_rom (
    .slot  (slot_nx),
    .index (counter_nx),
    .data  (rom_data),
    .count (rom_count)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      slot_q    <= '0;
      counter_q <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      inv_q     <= 1'b0;
      abort_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      state     <= state_nx;
      slot_q    <= slot_nx;
      counter_q <= counter_nx;
      retry_q   <= retry_nx;
      timer_q   <= timer_nx;
      done_q    <= done_nx;
      inv_q     <= inv_nx;
      abort_q   <= abort_nx;
      payload_q <= payload_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    slot_nx    = slot_q;
    counter_nx = counter_q;
    retry_nx   = retry_q;
    timer_nx   = timer_q;
    done_nx    = 1'b0;
    inv_nx     = 1'b0;
    abort_nx   = 1'b0;
    if (!bus.Enable) begin
      state_nx   = ST_IDLE;
      counter_nx = '0;
      retry_nx   = '0;
      timer_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Request) begin
            if (bus.slot == SLOT_INVALID) begin
              inv_nx = 1'b1;
            end else begin
              slot_nx    = bus.slot;
              counter_nx = 8'd1;
              retry_nx   = '0;
              state_nx   = ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (bus.Payload_ready) begin
            timer_nx = '0;
            state_nx = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          timer_nx = timer_q + 16'd1;
          // Ack wins over a simultaneous Nack or timer expiry.
          if (bus.Ack) begin
            if (counter_q == rom_count) begin
              done_nx    = 1'b1;
              counter_nx = '0;
              state_nx   = ST_IDLE;
            end else begin
              counter_nx = counter_q + 8'd1;
              retry_nx   = '0;
              state_nx   = ST_SEND;
            end
          end else if (bus.Nack || (timer_q == TIMER_LAST)) begin
            if (retry_q < RETRY_LIMIT) begin
              retry_nx = retry_q + 1'b1;
              state_nx = ST_SEND;
            end else begin
              abort_nx   = 1'b1;
              counter_nx = '0;
              state_nx   = ST_IDLE;
            end
          end
        end
        default: begin
          state_nx   = ST_IDLE;
          counter_nx = '0;
        end
      endcase
    end
    payload_nx = (state_nx == ST_SEND) ? rom_data : '0;
  end

  always_comb begin
    bus.Busy               = (state != ST_IDLE);
    bus.Payload_valid      = (state == ST_SEND);
    bus.Payload_out        = payload_q;
    bus.counter            = counter_q;
    bus.Done               = done_q;
    bus.Error_Invalid_Slot = inv_q;
    bus.Error_Abort        = abort_q;
    dbg_state              = state;
  end

endmodule

// File: tb/tb_certificate_sender.sv
// Directed bench for certificate_sender: expected chunks are queued by the
// stimulus and checked by a negedge monitor at every payload handshake.
module tb_certificate_sender;
  import certificate_sender_pkg::*;

  localparam int TOUT = 16;

  logic   clk;
  logic   Reset;
  state_e dbg_state;

  certificate_sender_if bus ();

  certificate_sender #(.TIMEOUT_CYCLES(TOUT), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hand-written chunk table, independent of the RTL package
  logic [31:0] cert0 [1:6] = '{32'h3082_0101, 32'h5A17_C302, 32'h9E44_0B13,
                                32'h1D6F_A024, 32'hC3B2_7E35, 32'h0F0F_F0F6};
  logic [31:0] cert1 [1:4] = '{32'h7711_2201, 32'hB00C_5A12, 32'h4E4F_C0F3, 32'hDEAD_BEE4};
  logic [31:0] cert2 [1:5] = '{32'h1234_5671, 32'hFACE_0B02, 32'h8888_1113,
                                32'h600D_F00D, 32'hCAFE_D00D};

  logic [39:0] exp_q[$];
  int          xfer_cyc_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          done_cycles = 0, abort_cycles = 0, inv_cycles = 0, valid_cycles = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_chunk(input int s, input int k);
    logic [31:0] d;
    case (s)
      0:       d = cert0[k];
      1:       d = cert1[k];
      default: d = cert2[k];
    endcase
    exp_q.push_back({8'(k), d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (bus.Done)               done_cycles++;
    if (bus.Error_Abort)        abort_cycles++;
    if (bus.Error_Invalid_Slot) inv_cycles++;
    if (bus.Payload_valid)      valid_cycles++;
    if (stall_prev && bus.Payload_valid) check("hold_data", 64'(bus.Payload_out), 64'(stall_data));
    stall_prev = bus.Payload_valid && !bus.Payload_ready;
    stall_data = bus.Payload_out;
    if (bus.Payload_valid && bus.Payload_ready) begin
      xfer_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_xfer: got counter %0d data %0h, expected none",
                 bus.counter, bus.Payload_out);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("xfer_counter", 64'(bus.counter), 64'(e[39:32]));
        check("xfer_data", 64'(bus.Payload_out), 64'(e[31:0]));
      end
    end
  end

  // driver tasks
  task automatic request(input logic [1:0] s);
    @(posedge clk); #1;
    bus.Request = 1'b1;
    bus.slot    = s;
    @(posedge clk); #1;
    bus.Request = 1'b0;
    bus.slot    = 2'd0;
  endtask

  task automatic wait_xfer();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.Payload_valid && bus.Payload_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_xfer: no handshake within 100 cycles, expected one");
    end
  endtask

  // call at the negedge before the handshake edge; answers 3 cycles later
  task automatic ack_after(input bit nack);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    if (nack) bus.Nack = 1'b1; else bus.Ack = 1'b1;
    @(posedge clk); #1;
    bus.Ack  = 1'b0;
    bus.Nack = 1'b0;
  endtask

  task automatic run_chunk(input bit nack);
    wait_xfer();
    ack_after(nack);
  endtask

  task automatic check_done(input string name, input int d0);
    @(negedge clk);
    check({name, "_done"}, 64'(bus.Done), 64'd1);
    check({name, "_busy_low"}, 64'(bus.Busy), 64'd0);
    check({name, "_counter0"}, 64'(bus.counter), 64'd0);
    repeat (3) @(negedge clk);
    check({name, "_done_1cyc"}, 64'(done_cycles - d0), 64'd1);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int d0, a0, i0, v0;
    bit seen;
    Reset = 1'b1;
    bus.Enable = 1'b1; bus.Request = 1'b0; bus.slot = 2'd0;
    bus.Payload_ready = 1'b1; bus.Ack = 1'b0; bus.Nack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_valid", 64'(bus.Payload_valid), 64'd0);
    check("rst_counter", 64'(bus.counter), 64'd0);
    check("rst_payload", 64'(bus.Payload_out), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1 Reset = 1'b0;

    // slot 0, full sequence with prompt acks
    d0 = done_cycles;
    for (int k = 1; k <= 6; k++) push_chunk(0, k);
    request(2'd0);
    @(negedge clk);
    check("s0_latency_valid", 64'(bus.Payload_valid), 64'd1);
    check("s0_busy", 64'(bus.Busy), 64'd1);
    check("s0_counter1", 64'(bus.counter), 64'd1);
    ack_after(1'b0);
    for (int k = 2; k <= 6; k++) run_chunk(1'b0);
    check_done("s0", d0);

    // slot 2, framer stalls on chunk 3
    d0 = done_cycles;
    for (int k = 1; k <= 5; k++) push_chunk(2, k);
    request(2'd2);
    run_chunk(1'b0);
    run_chunk(1'b0);
    bus.Payload_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s2_stall_valid", 64'(bus.Payload_valid), 64'd1);
    check("s2_stall_counter", 64'(bus.counter), 64'd3);
    check("s2_stall_data", 64'(bus.Payload_out), 64'h8888_1113);
    @(posedge clk); #1 bus.Payload_ready = 1'b1;
    for (int k = 3; k <= 5; k++) run_chunk(1'b0);
    check_done("s2", d0);

    // slot 1, Nack on chunk 2 forces one retransmission
    d0 = done_cycles;
    push_chunk(1, 1); push_chunk(1, 2); push_chunk(1, 2); push_chunk(1, 3); push_chunk(1, 4);
    request(2'd1);
    run_chunk(1'b0);
    run_chunk(1'b1);
    for (int k = 2; k <= 4; k++) run_chunk(1'b0);
    check_done("s1", d0);

    // invalid slot
    i0 = inv_cycles; v0 = valid_cycles;
    request(2'd3);
    @(negedge clk);
    check("inv_pulse", 64'(bus.Error_Invalid_Slot), 64'd1);
    repeat (4) @(negedge clk);
    check("inv_1cyc", 64'(inv_cycles - i0), 64'd1);
    check("inv_no_valid", 64'(valid_cycles - v0), 64'd0);
    check("inv_busy", 64'(bus.Busy), 64'd0);

    // no answers: three attempts TOUT wait cycles apart, then abort
    a0 = abort_cycles;
    xfer_cyc_q.delete();
    for (int r = 0; r < 3; r++) push_chunk(0, 1);
    request(2'd0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.Error_Abort) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL abort_wait: no Error_Abort within 200 cycles, expected one");
    end
    check("abort_counter0", 64'(bus.counter), 64'd0);
    check("abort_busy", 64'(bus.Busy), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_1cyc", 64'(abort_cycles - a0), 64'd1);
    check("abort_sends", 64'(xfer_cyc_q.size()), 64'd3);
    if (xfer_cyc_q.size() == 3) begin
      // TOUT cycles in WAIT_ACK plus the resend cycle
      check("abort_gap1", 64'(xfer_cyc_q[1] - xfer_cyc_q[0]), 64'(TOUT + 1));
      check("abort_gap2", 64'(xfer_cyc_q[2] - xfer_cyc_q[1]), 64'(TOUT + 1));
    end
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

    // async reset while waiting for the ack of chunk 4
    for (int k = 1; k <= 4; k++) push_chunk(0, k);
    request(2'd0);
    for (int k = 1; k <= 3; k++) run_chunk(1'b0);
    wait_xfer();
    @(posedge clk);
    @(posedge clk);
    check("pre_rst_counter", 64'(bus.counter), 64'd4);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.Busy), 64'd0);
    check("async_rst_counter", 64'(bus.counter), 64'd0);
    check("async_rst_valid", 64'(bus.Payload_valid), 64'd0);
    @(posedge clk); #1 Reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 64'(bus.Busy), 64'd0);

    // Enable drop mid-transfer: back to IDLE, no Done
    d0 = done_cycles;
    push_chunk(1, 1);
    request(2'd1);
    wait_xfer();
    @(posedge clk); #1 bus.Enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("en_low_busy", 64'(bus.Busy), 64'd0);
    check("en_low_counter", 64'(bus.counter), 64'd0);
    bus.Enable = 1'b1;
    repeat (3) @(negedge clk);
    check("en_low_no_done", 64'(done_cycles - d0), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
